// File: rtl/peri_bus_bridge.sv
// Core-to-peripheral bus bridge. Stores are queued and issued one per cycle.
// Loads run a fixed-latency read sequence and return a one-cycle response strobe.
//
// state   | meaning
// IDLE    | issue queued stores, or accept a load when the queue is empty
// RD_ADDR | read address on the peripheral bus for one cycle
// RD_WAIT | wait out the read latency, then sample peri_data_i
// RD_RESP | present the load response for one cycle
module peri_bus_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] peri_address_o,
    output logic [31:0] peri_data_o,
    input  logic [31:0] peri_data_i,
    output logic        busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_WAIT, RD_RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [1:0]    lat_q, lat_d;
    logic [31:0]   cmd_addr_d, cmd_data_d;
    logic          push, pop, st_gnt, ld_gnt, rd_sample;

    // Full status is judged on the pre-pop count, so a full queue never grants.
    assign st_gnt = req_i & we_i & (count_q < CW'(FIFO_DEPTH));
    assign push   = st_gnt;
    assign pop    = (state_q == IDLE) & (count_q != '0);
    assign ld_gnt = req_i & ~we_i & (count_q == '0) & (state_q == IDLE) & ~push;
    assign gnt_o  = st_gnt | ld_gnt;

    assign rvalid_o = (state_q == RD_RESP);
    assign busy_o   = (count_q != '0) | (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        cmd_addr_d = '0;
        cmd_data_d = '0;
        rd_sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cmd_addr_d = fifo_addr[rd_ptr_q];
                    cmd_data_d = fifo_data[rd_ptr_q];
                end else if (ld_gnt) begin
                    // The command register doubles as the latched read address.
                    cmd_addr_d = addr_i;
                    state_d    = RD_ADDR;
                end
            end
            RD_ADDR: begin
                lat_d   = 2'(RD_LAT - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    rd_sample = 1'b1;
                    state_d   = RD_RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            lat_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            peri_address_o <= '0;
            peri_data_o    <= '0;
            rdata_o        <= '0;
        end else begin
            state_q        <= state_d;
            lat_q          <= lat_d;
            peri_address_o <= cmd_addr_d;
            peri_data_o    <= cmd_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (rd_sample) rdata_o <= peri_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= addr_i;
            fifo_data[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_peri_bus_bridge.sv
// Bench for peri_bus_bridge: scoreboarded random traffic on a RD_LAT=1 instance,
// plus directed fill/latency/reset scenarios on a RD_LAT=4 instance.
module tb_peri_bus_bridge;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    typedef struct { int t; logic [31:0] a; logic [31:0] d; } bus_t;
    typedef struct { int t; logic [31:0] d; } rsp_t;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic        gnt_o, rvalid_o, busy_o;
    logic [31:0] rdata_o, peri_address_o, peri_data_o, peri_data_i;

    logic        req4, we4;
    logic [31:0] addr4, wdata4;
    logic        gnt4, rvalid4, busy4;
    logic [31:0] rdata4, pa4, pd4;

    logic        fix_en = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    int          dec_q[$];
    int          last_d   = -100;
    int          ld_start = -100;
    logic [31:0] last_rd  = '0;
    bus_t        mb;
    rsp_t        mr;

    bus_t        obs4_q[$];
    int          rv4_t[$];
    logic [31:0] rv4_d[$];

    peri_bus_bridge #(.FIFO_DEPTH(DEPTH), .RD_LAT(LAT)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .peri_address_o(peri_address_o), .peri_data_o(peri_data_o),
        .peri_data_i(peri_data_i), .busy_o(busy_o)
    );

    peri_bus_bridge #(.FIFO_DEPTH(4), .RD_LAT(4)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req4), .we_i(we4),
        .addr_i(addr4), .wdata_i(wdata4), .gnt_o(gnt4), .rvalid_o(rvalid4),
        .rdata_o(rdata4), .peri_address_o(pa4), .peri_data_o(pd4),
        .peri_data_i(peri_data_i), .busy_o(busy4)
    );

    function automatic logic [31:0] pdat(int k);
        logic [15:0] lo;
        lo = k[15:0];
        return {lo ^ 16'hC3A5, lo + 16'h1000};
    endfunction

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    assign peri_data_i = fix_en ? 32'hDEAD_BEEF : pdat(cyc);

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Cycles during which a load sequence owns the bridge (after its grant cycle).
    function automatic bit in_rd(int k);
        return (k >= ld_start + 1) && (k <= ld_start + LAT + 2);
    endfunction

    // One cycle of main-instance stimulus; the model decides grant and schedules expectations.
    task automatic step(bit r, bit w, logic [31:0] a, logic [31:0] d, output bit g);
        int cnt, dd;
        bit eg;
        @(posedge clk_i);
        #1;
        req_i = r; we_i = w; addr_i = a; wdata_i = d;
        #1;
        while (dec_q.size() != 0 && dec_q[0] < cyc) void'(dec_q.pop_front());
        cnt = dec_q.size();
        eg  = r && (w ? (cnt < DEPTH) : (cnt == 0 && !in_rd(cyc)));
        check("gnt", gnt_o, eg);
        check("busy", busy_o, (cnt != 0) || in_rd(cyc));
        if (eg && w) begin
            dd = (cyc + 1 > last_d + 1) ? cyc + 1 : last_d + 1;
            if (in_rd(dd)) dd = ld_start + LAT + 3;
            dec_q.push_back(dd);
            last_d = dd;
            bus_q.push_back(bus_t'{dd + 1, a, d});
        end else if (eg) begin
            ld_start = cyc;
            bus_q.push_back(bus_t'{cyc + 1, a, 32'h0});
            rsp_q.push_back(rsp_t'{cyc + LAT + 2, fix_en ? 32'hDEAD_BEEF : pdat(cyc + LAT + 1)});
        end
        g = eg;
    endtask

    task automatic step4(bit r, bit w, logic [31:0] a, logic [31:0] d, output bit g);
        @(posedge clk_i);
        #1;
        req4 = r; we4 = w; addr4 = a; wdata4 = d;
        #1;
        g = gnt4;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus_q.size() != 0 && bus_q[0].t == cyc) begin
                mb = bus_q.pop_front();
                check("bus_addr", peri_address_o, mb.a);
                check("bus_data", peri_data_o, mb.d);
            end else if (peri_address_o != 0 || peri_data_o != 0) begin
                check("bus_idle", {peri_address_o, peri_data_o}, 64'h0);
            end
            if (rsp_q.size() != 0 && rsp_q[0].t == cyc) begin
                mr = rsp_q.pop_front();
                check("rvalid", rvalid_o, 1'b1);
                check("rdata", rdata_o, mr.d);
                last_rd = mr.d;
            end else begin
                if (rvalid_o) check("rvalid_idle", rvalid_o, 1'b0);
                check("rdata_hold", rdata_o, last_rd);
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (pa4 != 0 || pd4 != 0) obs4_q.push_back(bus_t'{cyc, pa4, pd4});
            if (rvalid4) begin
                rv4_t.push_back(cyc);
                rv4_d.push_back(rdata4);
            end
        end
    end

    initial begin
        bit          g;
        int          g0, ns;
        int          gc[5];
        int          exp_off[5];
        bus_t        exp4[$];
        logic        r, w;
        logic [31:0] a, d;

        req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
        req4 = 0; we4 = 0; addr4 = '0; wdata4 = '0;

        #3 rst_ni = 1'b0;
        #2;
        check("rst_addr", peri_address_o, 32'h0);
        check("rst_data", peri_data_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Back-to-back stores from idle.
        step(1, 1, 32'h10, 32'hA, g);
        step(1, 1, 32'h14, 32'hB, g);
        step(1, 1, 32'h18, 32'hC, g);
        repeat (3) step(0, 0, '0, '0, g);

        // Load with a fixed peripheral value.
        fix_en = 1'b1;
        step(1, 0, 32'h20, '0, g);
        repeat (5) step(0, 0, '0, '0, g);
        fix_en = 1'b0;

        // Store followed by a load held until granted.
        step(1, 1, 32'h30, 32'h33, g);
        g = 1'b0;
        for (int k = 0; k < 8 && !g; k++) step(1, 0, 32'h34, '0, g);
        repeat (5) step(0, 0, '0, '0, g);

        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
            // A store to address 0 carries zero data so its issue slot is indistinguishable from idle.
            d = (a == 32'h0) ? 32'h0 : $urandom;
            step(r, w, a, d, g);
        end
        repeat (20) step(0, 0, '0, '0, g);
        check("bus_q_drained", bus_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        // RD_LAT=4 instance: fill the queue behind a read, then check order and timing.
        obs4_q.delete(); rv4_t.delete(); rv4_d.delete();
        step4(1, 0, 32'h40, '0, g);
        check("ld4_gnt", g, 1'b1);
        g0 = cyc;
        ns = 0;
        for (int k = 0; k < 20 && ns < 5; k++) begin
            step4(1, 1, 32'(32'h100 + 4 * ns), 32'(32'hD0 + ns), g);
            if (g) begin
                gc[ns] = cyc;
                ns++;
            end
        end
        repeat (10) step4(0, 0, '0, '0, g);
        check("fill_grants", ns, 5);
        exp_off = '{1, 2, 3, 4, 8};
        for (int j = 0; j < 5; j++) check("fill_gnt_cycle", gc[j] - g0, exp_off[j]);
        exp4.push_back(bus_t'{g0 + 1, 32'h40, 32'h0});
        for (int j = 0; j < 5; j++)
            exp4.push_back(bus_t'{g0 + 8 + j, 32'(32'h100 + 4 * j), 32'(32'hD0 + j)});
        check("fill_bus_count", obs4_q.size(), exp4.size());
        for (int j = 0; j < exp4.size() && j < obs4_q.size(); j++) begin
            check("fill_bus_cycle", obs4_q[j].t - g0, exp4[j].t - g0);
            check("fill_bus_addr", obs4_q[j].a, exp4[j].a);
            check("fill_bus_data", obs4_q[j].d, exp4[j].d);
        end
        check("lat4_rvalid_count", rv4_t.size(), 1);
        if (rv4_t.size() != 0) begin
            check("lat4_rvalid_cycle", rv4_t[0] - g0, 6);
            check("lat4_rdata", rv4_d[0], pdat(g0 + 5));
        end

        // Reset in the middle of a read with two stores queued.
        obs4_q.delete(); rv4_t.delete(); rv4_d.delete();
        step4(1, 0, 32'h60, '0, g);
        step4(1, 1, 32'h200, 32'hE0, g);
        step4(1, 1, 32'h204, 32'hE1, g);
        @(posedge clk_i);
        #1 req4 = 1'b0;
        #1 check("rd_wait_busy", busy4, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        check("mid_rst_addr", pa4, 32'h0);
        check("mid_rst_data", pd4, 32'h0);
        check("mid_rst_rdata", rdata4, 32'h0);
        check("mid_rst_rvalid", rvalid4, 1'b0);
        check("mid_rst_busy", busy4, 1'b0);
        check("mid_rst_main_rdata", rdata_o, 32'h0);
        check("mid_rst_main_busy", busy_o, 1'b0);
        bus_q.delete(); rsp_q.delete(); dec_q.delete();
        last_d = -100; ld_start = -100; last_rd = '0;
        obs4_q.delete(); rv4_t.delete(); rv4_d.delete();
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (12) step4(0, 0, '0, '0, g);
        check("post_rst_stale_cmds", obs4_q.size(), 0);
        check("post_rst_stale_rvalid", rv4_t.size(), 0);

        // Immediate accept after release, then a short mixed tail.
        step(1, 1, 32'h70, 32'h77, g);
        step(1, 1, 32'h74, 32'h78, g);
        g = 1'b0;
        for (int k = 0; k < 8 && !g; k++) step(1, 0, 32'h78, '0, g);
        repeat (10) step(0, 0, '0, '0, g);
        check("bus_q_final", bus_q.size(), 0);
        check("rsp_q_final", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
